// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer_if
//  Brief    : Request/response handshake bundle for the shift sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   operand;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               busy;
    logic               err;

    modport master (
        output in_valid, op, shamt, operand, flush, out_ready,
        input  in_ready, out_valid, result, busy, err
    );

    modport slave (
        input  in_valid, op, shamt, operand, flush, out_ready,
        output in_ready, out_valid, result, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Brief    : Multi-cycle SLL/SRL/SRA unit, up to 2 bit positions per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire                clk,
    input  wire                rst_n,
    shift_sequencer_if.slave   bus
);

    localparam logic [1:0]         c_op_sll = 2'b00;
    localparam logic [1:0]         c_op_sra = 2'b10;
    localparam logic [1:0]         c_op_ill = 2'b11;
    localparam logic [SHAMT_W-1:0] c_two    = SHAMT_W'(2);
    localparam logic [SHAMT_W-1:0] c_zero   = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_next;
    logic [SHAMT_W-1:0] r_cnt;
    logic [SHAMT_W-1:0] w_cnt_next;
    logic [1:0]         r_op;
    logic [1:0]         w_op_next;
    logic               r_sign;
    logic               w_sign_next;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_next;
    logic               r_err;
    logic               w_err_next;

    logic               w_fill;
    logic               w_step2;
    logic [WIDTH-1:0]   w_shifted;
    logic [SHAMT_W-1:0] w_cnt_dec;

    // SRA replicates the sign captured at accept time, not the current MSB.
    assign w_fill  = (r_op == c_op_sra) && r_sign;
    assign w_step2 = (r_cnt >= c_two);

    always_comb begin
        w_shifted = r_data;
        w_cnt_dec = c_zero;
        if (w_step2) begin
            w_cnt_dec = r_cnt - c_two;
            if (r_op == c_op_sll) begin
                w_shifted = {r_data[WIDTH-3:0], 2'b00};
            end else begin
                w_shifted = {w_fill, w_fill, r_data[WIDTH-1:2]};
            end
        end else begin
            if (r_op == c_op_sll) begin
                w_shifted = {r_data[WIDTH-2:0], 1'b0};
            end else begin
                w_shifted = {w_fill, r_data[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_data_next   = r_data;
        w_cnt_next    = r_cnt;
        w_op_next     = r_op;
        w_sign_next   = r_sign;
        w_result_next = r_result;
        w_err_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // flush outranks a pending request in IDLE
                if (!bus.flush && bus.in_valid) begin
                    w_data_next = bus.operand;
                    w_op_next   = bus.op;
                    w_sign_next = bus.operand[WIDTH-1];
                    w_cnt_next  = bus.shamt;
                    if (bus.op == c_op_ill) begin
                        w_err_next    = 1'b1;
                        w_result_next = bus.operand;
                        w_state_next  = S_DONE;
                    end else if (bus.shamt == c_zero) begin
                        w_result_next = bus.operand;
                        w_state_next  = S_DONE;
                    end else begin
                        w_state_next  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_data_next = w_shifted;
                    w_cnt_next  = w_cnt_dec;
                    if (w_cnt_dec == c_zero) begin
                        w_result_next = w_shifted;
                        w_state_next  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.flush || bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_cnt    <= '0;
            r_op     <= 2'b00;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_data   <= w_data_next;
            r_cnt    <= w_cnt_next;
            r_op     <= w_op_next;
            r_sign   <= w_sign_next;
            r_result <= w_result_next;
            r_err    <= w_err_next;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = r_result;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_sequencer
//  Brief    : Directed self-checking bench for shift_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int c_width   = 32;
    localparam int c_shamt_w = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    shift_sequencer_if #(.WIDTH(c_width), .SHAMT_W(c_shamt_w)) bus ();

    shift_sequencer #(.WIDTH(c_width), .SHAMT_W(c_shamt_w)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request and returns #1 after the accept edge.
    task automatic start_op(input string tag, input logic [1:0] op, input logic [4:0] sh,
                            input logic [31:0] val);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.shamt    = sh;
        bus.operand  = val;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_err"}, 32'(bus.err), (op == 2'b11) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_res);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, {29'd0, bus.in_ready, bus.out_valid, bus.err}, 32'b100);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.shamt     = '0;
        bus.operand   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {28'd0, bus.out_valid, bus.busy, bus.err, 1'b0}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        start_op("sll2", 2'b00, 5'd2, 32'h0000_0001);
        wait_done("sll2", 2, 32'h0000_0004);
        release_result("sll2");

        start_op("sra31", 2'b10, 5'd31, 32'h8000_0000);
        wait_done("sra31", 17, 32'hFFFF_FFFF);
        release_result("sra31");

        start_op("srl31", 2'b01, 5'd31, 32'h8000_0000);
        wait_done("srl31", 17, 32'h0000_0001);
        release_result("srl31");

        start_op("sll0", 2'b00, 5'd0, 32'hDEAD_BEEF);
        wait_done("sll0", 1, 32'hDEAD_BEEF);
        release_result("sll0");

        start_op("srl5", 2'b01, 5'd5, 32'h0000_0100);
        wait_done("srl5", 4, 32'h0000_0008);
        release_result("srl5");

        // Backpressure: a competing request must be ignored while DONE is held
        start_op("bp", 2'b00, 5'd4, 32'h0000_0003);
        wait_done("bp", 3, 32'h0000_0030);
        bus.in_valid = 1'b1;
        bus.operand  = 32'hFFFF_0000;
        bus.shamt    = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {bus.result[27:0], bus.out_valid, bus.in_ready, 2'b00},
                {28'h000_0030, 1'b1, 1'b0, 2'b00});
        end
        bus.in_valid = 1'b0;
        release_result("bp");
        chk("bp_nobusy", 32'(bus.busy), 32'd0);

        // Flush during the second SHIFT cycle
        start_op("fl", 2'b00, 5'd8, 32'h0000_0001);
        @(posedge clk); #1;
        chk("fl_shift", {30'd0, bus.busy, bus.out_valid}, 32'b10);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("fl_idle", {30'd0, bus.in_ready, bus.busy}, 32'b10);
        chk("fl_result", bus.result, 32'h0000_0030);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("fl_noval", 32'(bus.out_valid), 32'd0);
        end
        start_op("b2b", 2'b01, 5'd4, 32'h0000_00F0);
        wait_done("b2b", 3, 32'h0000_000F);
        release_result("b2b");

        // Flush in IDLE wins over a simultaneous request
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_idle_pri", {30'd0, bus.in_ready, bus.busy}, 32'b10);

        start_op("ill", 2'b11, 5'd7, 32'h1234_5678);
        wait_done("ill", 1, 32'h1234_5678);
        @(posedge clk); #1;
        chk("ill_pulse", {30'd0, bus.err, bus.out_valid}, 32'b01);
        release_result("ill");

        // Asynchronous reset mid-SHIFT
        start_op("rst", 2'b10, 5'd10, 32'h8000_0000);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {28'd0, bus.out_valid, bus.busy, bus.err, 1'b0}, 32'd0);
        chk("rst_mid_res", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);

        start_op("sra1", 2'b10, 5'd1, 32'h8000_0004);
        wait_done("sra1", 2, 32'hC000_0002);
        release_result("sra1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
